// File: rtl/tdm_demux_1to8_if.sv
// Serial-in / parallel-out bus for the 1:8 TDM demultiplexer.
// Handshake: din and frame_start are sampled only on a rising clk where din_valid=1; there is no ready, so the block always accepts.
interface tdm_demux_1to8_if;
  logic       din;
  logic       din_valid;
  logic       frame_start;
  logic       y0, y1, y2, y3, y4, y5, y6, y7;
  logic       s2, s1, s0;
  logic       frame_valid;
  logic       frame_err;
  logic [7:0] frame_cnt;

  modport master (
    output din, din_valid, frame_start,
    input  y0, y1, y2, y3, y4, y5, y6, y7,
    input  s2, s1, s0, frame_valid, frame_err, frame_cnt
  );

  modport slave (
    input  din, din_valid, frame_start,
    output y0, y1, y2, y3, y4, y5, y6, y7,
    output s2, s1, s0, frame_valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/tdm_demux_1to8.sv
// Rebuilds eight channel bits from a slot-scanned serial stream and presents them
// as a registered parallel word once per complete frame.
module tdm_demux_1to8 (
  input  logic                    clk,
  input  logic                    rst_n,
  tdm_demux_1to8_if.slave         bus,
  output logic                    dbg_state_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t     state_q;
  logic [2:0] slot_q;
  logic [7:0] shadow_q;
  logic [7:0] y_q;
  logic       frame_valid_q;
  logic       frame_err_q;
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slot_q        <= 3'd0;
      shadow_q      <= 8'd0;
      y_q           <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (bus.din_valid) begin
        case (state_q)
          IDLE: begin
            // Bits arriving without a frame marker carry no slot reference.
            if (bus.frame_start) begin
              shadow_q[0] <= bus.din;
              slot_q      <= 3'd1;
              state_q     <= COLLECT;
            end
          end
          COLLECT: begin
            if (bus.frame_start) begin
              frame_err_q <= 1'b1;
              shadow_q    <= {7'd0, bus.din};
              slot_q      <= 3'd1;
            end else if (slot_q == 3'd7) begin
              y_q           <= {bus.din, shadow_q[6:0]};
              frame_valid_q <= 1'b1;
              frame_cnt_q   <= frame_cnt_q + 8'd1;
              slot_q        <= 3'd0;
              state_q       <= IDLE;
            end else begin
              shadow_q[slot_q] <= bus.din;
              slot_q           <= slot_q + 3'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            slot_q  <= 3'd0;
          end
        endcase
      end
    end
  end

  assign bus.y0          = y_q[0];
  assign bus.y1          = y_q[1];
  assign bus.y2          = y_q[2];
  assign bus.y3          = y_q[3];
  assign bus.y4          = y_q[4];
  assign bus.y5          = y_q[5];
  assign bus.y6          = y_q[6];
  assign bus.y7          = y_q[7];
  assign bus.s2          = slot_q[2];
  assign bus.s1          = slot_q[1];
  assign bus.s0          = slot_q[0];
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign dbg_state_o     = state_q;

endmodule
